cr_cmd_scheduler: RTL and testbench

//  Shares the single card-reader command channel (cr_cmd/cr_cmdvld/cr_ack/cr_rdata/cr_rdatavld)

---
 rtl/poker_cr_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/cr_cmd_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_cr_cmd_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_cr_pkg.sv
// Shared widths, opcodes and scheduler states for the card-reader command channel.
package poker_cr_pkg;

   localparam int CR_CMD_W   = 3;
   localparam int CR_WDATA_W = 6;
   localparam int CR_RDATA_W = 8;

   typedef enum logic [CR_CMD_W-1:0] {
      CR_NOP     = 3'd0,
      CR_DEAL    = 3'd1,
      CR_PEEK    = 3'd2,
      CR_DISCARD = 3'd3,
      CR_REPLACE = 3'd4,
      CR_BET     = 3'd5,
      CR_ACTION  = 3'd6,
      CR_STATUS  = 3'd7
   } cr_cmd_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } cr_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N) wins.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IW = $clog2(N);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(ptr_i) + i) % N);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
   end

endmodule

// File: rtl/cr_cmd_scheduler.sv
// Shares the single card-reader command channel between NUM_REQ requesters,
// one command outstanding at a time, with timeout and game-abort recovery.
module cr_cmd_scheduler
   import poker_cr_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tbl_game_over,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ*CR_CMD_W-1:0]   req_cmd,
   input  logic [NUM_REQ*CR_WDATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]            req_rd,
   output logic [NUM_REQ-1:0]            req_gnt,
   output logic [NUM_REQ-1:0]            rsp_vld,
   output logic                          rsp_err,
   output logic [CR_RDATA_W-1:0]         rsp_data,
   output logic                          busy,
   output logic                          cr_cmdvld,
   output logic [CR_CMD_W-1:0]           cr_cmd,
   output logic [CR_WDATA_W-1:0]         cr_wdata,
   input  logic                          cr_ack,
   input  logic [CR_RDATA_W-1:0]         cr_rdata,
   input  logic                          cr_rdatavld
);

   localparam int IDW   = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   cr_sched_state_e         state_q, state_d;
   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [IDW-1:0]          id_q, id_d;
   logic [CR_CMD_W-1:0]     cmd_q, cmd_d;
   logic [CR_WDATA_W-1:0]   wdata_q, wdata_d;
   logic                    rd_q, rd_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic                    cmdvld_q, cmdvld_d;
   logic                    busy_q, busy_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [CR_RDATA_W-1:0]   rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0]      arb_gnt;
   logic [IDW-1:0]          arb_idx;
   logic                    expired;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i (req_vld),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign expired = (timer_q == TMR_LAST);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      cmd_d      = cmd_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      timer_d    = timer_q;
      cmdvld_d   = cmdvld_q;
      gnt_d      = '0;
      rsp_vld_d  = '0;
      rsp_err_d  = 1'b0;
      rsp_data_d = '0;

      case (state_q)
         IDLE: begin
            cmdvld_d = 1'b0;
            if ((|req_vld) && !tbl_game_over) begin
               state_d  = ISSUE;
               id_d     = arb_idx;
               ptr_d    = arb_idx;
               gnt_d    = arb_gnt;
               cmdvld_d = 1'b1;
               timer_d  = '0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (arb_gnt[i]) begin
                     cmd_d   = req_cmd[i*CR_CMD_W +: CR_CMD_W];
                     wdata_d = req_wdata[i*CR_WDATA_W +: CR_WDATA_W];
                     rd_d    = req_rd[i];
                  end
               end
            end
         end

         ISSUE: begin
            timer_d = timer_q + 1'b1;
            // Abort beats everything; ack beats a same-cycle timeout.
            if (tbl_game_over || (expired && !cr_ack)) begin
               state_d          = IDLE;
               cmdvld_d         = 1'b0;
               rsp_vld_d[id_q]  = 1'b1;
               rsp_err_d        = 1'b1;
            end else if (cr_ack) begin
               cmdvld_d = 1'b0;
               if (!rd_q) begin
                  state_d         = IDLE;
                  rsp_vld_d[id_q] = 1'b1;
               end else if (cr_rdatavld) begin
                  state_d         = IDLE;
                  rsp_vld_d[id_q] = 1'b1;
                  rsp_data_d      = cr_rdata;
               end else begin
                  state_d = WAIT_DATA;
                  timer_d = '0;
               end
            end
         end

         WAIT_DATA: begin
            timer_d = timer_q + 1'b1;
            if (tbl_game_over || (expired && !cr_rdatavld)) begin
               state_d         = IDLE;
               rsp_vld_d[id_q] = 1'b1;
               rsp_err_d       = 1'b1;
            end else if (cr_rdatavld) begin
               state_d         = IDLE;
               rsp_vld_d[id_q] = 1'b1;
               rsp_data_d      = cr_rdata;
            end
         end

         default: begin
            state_d  = IDLE;
            cmdvld_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= IDW'(NUM_REQ - 1);
         id_q       <= '0;
         cmd_q      <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         timer_q    <= '0;
         cmdvld_q   <= 1'b0;
         busy_q     <= 1'b0;
         gnt_q      <= '0;
         rsp_vld_q  <= '0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         cmd_q      <= cmd_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         timer_q    <= timer_d;
         cmdvld_q   <= cmdvld_d;
         busy_q     <= busy_d;
         gnt_q      <= gnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_err_q  <= rsp_err_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign req_gnt   = gnt_q;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;
   assign cr_cmdvld = cmdvld_q;
   assign cr_cmd    = cmd_q;
   assign cr_wdata  = wdata_q;

endmodule

// File: tb/tb_cr_cmd_scheduler.sv
// Directed bench for cr_cmd_scheduler: per-cycle vector table plus hand-written
// sequences for round-robin, game abort and mid-command reset.
module tb_cr_cmd_scheduler;

   logic        clk;
   logic        rst_n;
   logic        tbl_game_over;
   logic [2:0]  req_vld;
   logic [8:0]  req_cmd;
   logic [17:0] req_wdata;
   logic [2:0]  req_rd;
   logic [2:0]  req_gnt;
   logic [2:0]  rsp_vld;
   logic        rsp_err;
   logic [7:0]  rsp_data;
   logic        busy;
   logic        cr_cmdvld;
   logic [2:0]  cr_cmd;
   logic [5:0]  cr_wdata;
   logic        cr_ack;
   logic [7:0]  cr_rdata;
   logic        cr_rdatavld;

   int checks = 0;
   int errors = 0;

   cr_cmd_scheduler #(.NUM_REQ(3), .TIMEOUT_CYC(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tbl_game_over (tbl_game_over),
      .req_vld       (req_vld),
      .req_cmd       (req_cmd),
      .req_wdata     (req_wdata),
      .req_rd        (req_rd),
      .req_gnt       (req_gnt),
      .rsp_vld       (rsp_vld),
      .rsp_err       (rsp_err),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .cr_cmdvld     (cr_cmdvld),
      .cr_cmd        (cr_cmd),
      .cr_wdata      (cr_wdata),
      .cr_ack        (cr_ack),
      .cr_rdata      (cr_rdata),
      .cr_rdatavld   (cr_rdatavld)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] req;
      logic [2:0] rd;
      logic       ack;
      logic       dv;
      logic [7:0] rdata;
      logic       go;
      logic [2:0] e_gnt;
      logic       e_cv;
      logic [2:0] e_rsp;
      logic       e_err;
      logic [7:0] e_data;
      logic       e_busy;
      int         e_own;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string nm, logic [2:0] req, logic [2:0] rd, logic ack, logic dv,
                               logic [7:0] rdata, logic go, logic [2:0] e_gnt, logic e_cv,
                               logic [2:0] e_rsp, logic e_err, logic [7:0] e_data, logic e_busy,
                               int e_own);
      vec_t v;
      v.name = nm; v.req = req; v.rd = rd; v.ack = ack; v.dv = dv; v.rdata = rdata; v.go = go;
      v.e_gnt = e_gnt; v.e_cv = e_cv; v.e_rsp = e_rsp; v.e_err = e_err; v.e_data = e_data;
      v.e_busy = e_busy; v.e_own = e_own;
      return v;
   endfunction

   function automatic logic [2:0] exp_cmd(int own);
      return 3'(own + 1);
   endfunction

   function automatic logic [5:0] exp_wdata(int own);
      return 6'((own + 1) * 17);
   endfunction

   function automatic logic [16:0] outs();
      return {req_gnt, cr_cmdvld, rsp_vld, rsp_err, rsp_data, busy};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [2:0] req, logic [2:0] rd, logic ack, logic dv, logic [7:0] rdata,
                        logic go);
      req_vld = req; req_rd = rd; cr_ack = ack; cr_rdatavld = dv; cr_rdata = rdata;
      tbl_game_over = go;
   endtask

   // scoreboard
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   logic [1:0] exp_q[$];

   initial begin
      logic [31:0] act, exp;
      int          n_gnt, n_rsp, outstanding, cv_cnt, cur_own, got;

      rst_n = 1'b0;
      req_cmd   = {3'd3, 3'd2, 3'd1};
      req_wdata = {6'h33, 6'h22, 6'h11};
      drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);

      #3;
      check("rst_outputs", {6'h0, outs(), cr_cmd, cr_wdata}, 32'h0);
      #20;
      rst_n = 1'b1;
      step();
      check("rst_idle", {15'h0, outs()}, 32'h0);

      // test 1: read, ack at +3, data 0x2C at +5
      vecs.push_back(mk("t1_gnt",   3'b001, 3'b001, 0, 0, 8'h00, 0, 3'b001, 1, 3'b000, 0, 8'h00, 1, 0));
      vecs.push_back(mk("t1_c2",    3'b000, 3'b001, 0, 0, 8'h00, 0, 3'b000, 1, 3'b000, 0, 8'h00, 1, 0));
      vecs.push_back(mk("t1_c3",    3'b000, 3'b001, 0, 0, 8'h00, 0, 3'b000, 1, 3'b000, 0, 8'h00, 1, 0));
      vecs.push_back(mk("t1_ack",   3'b000, 3'b001, 1, 0, 8'h00, 0, 3'b000, 0, 3'b000, 0, 8'h00, 1, 0));
      vecs.push_back(mk("t1_wait",  3'b000, 3'b001, 0, 0, 8'h00, 0, 3'b000, 0, 3'b000, 0, 8'h00, 1, 0));
      vecs.push_back(mk("t1_data",  3'b000, 3'b001, 0, 1, 8'h2C, 0, 3'b000, 0, 3'b001, 0, 8'h2C, 0, 0));
      vecs.push_back(mk("t1_stray", 3'b000, 3'b001, 0, 1, 8'h55, 0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0));
      // test 3: ack and data in the same cycle
      vecs.push_back(mk("t3_gnt",   3'b010, 3'b010, 0, 0, 8'h00, 0, 3'b010, 1, 3'b000, 0, 8'h00, 1, 1));
      vecs.push_back(mk("t3_both",  3'b000, 3'b010, 1, 1, 8'h3F, 0, 3'b000, 0, 3'b010, 0, 8'h3F, 0, 1));
      vecs.push_back(mk("t3_idle",  3'b000, 3'b010, 0, 0, 8'h00, 0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 1));
      // test 4: silent reader, TIMEOUT_CYC=8
      vecs.push_back(mk("t4_gnt",   3'b100, 3'b000, 0, 0, 8'hAA, 0, 3'b100, 1, 3'b000, 0, 8'h00, 1, 2));
      for (int k = 2; k <= 8; k++)
         vecs.push_back(mk($sformatf("t4_wait%0d", k), 3'b000, 3'b000, 0, (k == 4), 8'hAA, 0,
                           3'b000, 1, 3'b000, 0, 8'h00, 1, 2));
      vecs.push_back(mk("t4_tmo",   3'b000, 3'b000, 0, 0, 8'hAA, 0, 3'b000, 0, 3'b100, 1, 8'h00, 0, 2));
      vecs.push_back(mk("t4_late",  3'b000, 3'b000, 1, 0, 8'hAA, 0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 2));
      vecs.push_back(mk("t4_idle",  3'b000, 3'b000, 0, 0, 8'hAA, 0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 2));

      foreach (vecs[i]) begin
         drive(vecs[i].req, vecs[i].rd, vecs[i].ack, vecs[i].dv, vecs[i].rdata, vecs[i].go);
         step();
         act = {6'h0, outs(), (cr_cmdvld ? cr_cmd : 3'd0), (cr_cmdvld ? cr_wdata : 6'd0)};
         exp = {6'h0, vecs[i].e_gnt, vecs[i].e_cv, vecs[i].e_rsp, vecs[i].e_err, vecs[i].e_data,
                vecs[i].e_busy, (vecs[i].e_cv ? exp_cmd(vecs[i].e_own) : 3'd0),
                (vecs[i].e_cv ? exp_wdata(vecs[i].e_own) : 6'd0)};
         check(vecs[i].name, act, exp);
      end
      drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);

      // test 2: all three requesting, ack two cycles after each cr_cmdvld rise
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd0);
      req_vld = 3'b111;
      n_gnt = 0; n_rsp = 0; outstanding = 0; cv_cnt = 0; cur_own = 0;
      for (int cyc = 0; cyc < 60 && n_rsp < 4; cyc++) begin
         step();
         if (req_gnt != 3'b000) begin
            got = 0;
            for (int j = 0; j < 3; j++) if (req_gnt[j]) got = j;
            check("t2_one_outstanding", outstanding, 0);
            if (exp_q.size() > 0) check("t2_order", got, {30'h0, exp_q.pop_front()});
            check("t2_cmd", {cr_cmdvld, cr_cmd, cr_wdata}, {1'b1, exp_cmd(got), exp_wdata(got)});
            outstanding++;
            cur_own = got;
            n_gnt++;
            if (n_gnt == 4) req_vld = 3'b000;
         end
         if (rsp_vld != 3'b000) begin
            check("t2_rsp", {rsp_vld, rsp_err, rsp_data}, {3'(1 << cur_own), 1'b0, 8'h00});
            outstanding--;
            n_rsp++;
         end
         cv_cnt = cr_cmdvld ? cv_cnt + 1 : 0;
         cr_ack = (cv_cnt == 3);
      end
      check("t2_done", n_rsp, 4);
      drive(3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
      step();

      // test 5: game over in WAIT_DATA, then grants blocked while it stays high
      drive(3'b010, 3'b010, 0, 0, 8'h00, 0);
      step();
      check("t5_gnt", {15'h0, outs()}, {15'h0, 3'b010, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1});
      drive(3'b000, 3'b010, 1, 0, 8'h00, 0);
      step();
      check("t5_wait", {15'h0, outs()}, {15'h0, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1});
      drive(3'b000, 3'b010, 0, 0, 8'h00, 0);
      step();
      drive(3'b000, 3'b010, 0, 1, 8'h15, 1);
      step();
      check("t5_abort", {15'h0, outs()}, {15'h0, 3'b000, 1'b0, 3'b010, 1'b1, 8'h00, 1'b0});
      drive(3'b100, 3'b010, 0, 0, 8'h00, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t5_blocked", {15'h0, outs()}, 32'h0);
      end
      tbl_game_over = 1'b0;
      step();
      check("t5_resume", {15'h0, outs()}, {15'h0, 3'b100, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1});
      drive(3'b000, 3'b010, 1, 0, 8'h00, 0);
      step();
      check("t5_rsp", {15'h0, outs()}, {15'h0, 3'b000, 1'b0, 3'b100, 1'b0, 8'h00, 1'b0});
      drive(3'b000, 3'b000, 0, 0, 8'h00, 0);
      step();

      // test 6: reset in WAIT_DATA, then fresh arbitration
      drive(3'b001, 3'b001, 0, 0, 8'h00, 0);
      step();
      check("t6_gnt", {15'h0, outs()}, {15'h0, 3'b001, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1});
      drive(3'b000, 3'b001, 1, 0, 8'h00, 0);
      step();
      check("t6_wait", {15'h0, outs()}, {15'h0, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1});
      cr_ack = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_now", {6'h0, outs(), cr_cmd, cr_wdata}, 32'h0);
      cr_rdatavld = 1'b1; cr_rdata = 8'h77;
      step();
      check("t6_rst_hold", {6'h0, outs(), cr_cmd, cr_wdata}, 32'h0);
      @(negedge clk);
      drive(3'b111, 3'b000, 0, 0, 8'h00, 0);
      rst_n = 1'b1;
      step();
      check("t6_tie", {15'h0, outs()}, {15'h0, 3'b001, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1});
      drive(3'b000, 3'b000, 1, 0, 8'h00, 0);
      step();
      check("t6_rsp", {15'h0, outs()}, {15'h0, 3'b000, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0});
      drive(3'b000, 3'b000, 0, 0, 8'h00, 0);
      step();

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
